// File: rtl/truth_table_scanner.sv
// ============================================================================
// truth_table_scanner
// ----------------------------------------------------------------------------
// Purpose:
//   Exhaustively exercises a 3-input combinational circuit. The scanner drives
//   each input vector {A,B,C} = 0..7 in turn, with A as the MSB. It holds each
//   vector for SETTLE cycles so the circuit's output can settle, and then
//   samples O for one cycle. The captured truth table is compared against a
//   golden table. That golden table is latched when the scan starts.
//
// Parameters:
//   SETTLE        cycles each vector is held before O is sampled (1..15)
//
// Ports:
//   clk           single clock, rising-edge active
//   rst_n         synchronous active-low reset
//   start         single-cycle scan request, honoured only in IDLE
//   expected[7:0] golden truth table; bit i is the expected O for vector i
//   a_out/b_out/c_out  stimulus to the circuit under test (a_out = MSB)
//   o_in          response O from the circuit under test
//   table_out[7:0] captured truth table; bit i is the O sampled for vector i
//   busy          high in every state except IDLE
//   done          one-cycle pulse when a scan completes
//   pass          table_out matched the golden table at the end of the scan
//   mismatch_cnt[3:0]  (TRUTH_TABLE_SCANNER_MISMATCH_CNT_EN only) count of
//                 differing bits between table_out and the golden table
//
// Configuration:
//   `define TRUTH_TABLE_SCANNER_MISMATCH_CNT_EN adds the mismatch_cnt output.
// ============================================================================
module truth_table_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    input  logic       o_in,
    output logic [7:0] table_out,
    output logic       busy,
    output logic       done,
    output logic       pass
`ifdef TRUTH_TABLE_SCANNER_MISMATCH_CNT_EN
    ,
    output logic [3:0] mismatch_cnt
`endif
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
        $error("truth_table_scanner: SETTLE must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // The last DRIVE cycle is the one in which the settle count reads SETTLE-1.
    // The counter is post-incremented, so DRIVE lasts exactly SETTLE cycles.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic [7:0] expected_q;

`ifdef TRUTH_TABLE_SCANNER_MISMATCH_CNT_EN
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default on entry, so
    // that no path leaves one unassigned. A path that left one unassigned
    // would infer a latch.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        {a_out, b_out, c_out} = 3'b000;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                {a_out, b_out, c_out} = idx;
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                {a_out, b_out, c_out} = idx;
                state_next = (idx == 3'd7) ? DONE : DRIVE;
            end
            DONE: begin
                // Any start seen here is dropped. A new scan has to be
                // requested from IDLE.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments. Every register
    // therefore sees the values from before the clock edge, whatever order the
    // statements appear in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            expected_q <= 8'h00;
            table_out  <= 8'h00;
            done       <= 1'b0;
            pass       <= 1'b0;
`ifdef TRUTH_TABLE_SCANNER_MISMATCH_CNT_EN
            mismatch_cnt <= 4'd0;
`endif
        end else begin
            state <= state_next;
            // done is registered from the DONE state, so the pulse comes one
            // cycle after DONE. It lines up with the updated pass value.
            done  <= (state == DONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        expected_q <= expected;
                        table_out  <= 8'h00;
                        pass       <= 1'b0;
                        idx        <= 3'd0;
                        settle_cnt <= 4'd0;
`ifdef TRUTH_TABLE_SCANNER_MISMATCH_CNT_EN
                        mismatch_cnt <= 4'd0;
`endif
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    table_out[idx] <= o_in;
                    if (idx != 3'd7) begin
                        idx        <= idx + 3'd1;
                        settle_cnt <= 4'd0;
                    end
                end
                DONE: begin
                    // table_out already holds the bit sampled for vector 7.
                    pass <= (table_out == expected_q);
`ifdef TRUTH_TABLE_SCANNER_MISMATCH_CNT_EN
                    mismatch_cnt <= popcount8(table_out ^ expected_q);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
